pipelined_add_sub: RTL
======================

PIPELINED_ADD_SUB -- requirements
Module: pipelined_add_sub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, giving the pipeline depth; legal values are 1..WIDTH with WIDTH % STAGES == 0.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_valid, input, 1 bit: operand set present.
REQ-006 The block SHALL have port o_ready, output, 1 bit: block accepts an operand set this cycle.
REQ-007 The block SHALL have ports i_a and i_b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port i_op, input, 2 bits: 00 ADD, 01 SUB, 10 ADDC, 11 SUBB.
REQ-009 The block SHALL have port i_cin, input, 1 bit: carry-in for ADDC; borrow-in for SUBB (1 means borrow).
REQ-010 The block SHALL have port o_valid, output, 1 bit: result present.
REQ-011 The block SHALL have port i_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have port o_result, output, WIDTH bits: sum or difference.
REQ-013 The block SHALL have ports o_c, o_v, o_z and o_n, output, 1 bit each: carry/no-borrow, signed overflow, zero, negative.

Function
REQ-014 The block SHALL compute ADD as A+B, SUB as A+~B+1, ADDC as A+B+cin and SUBB as A+~B+~cin, all modulo 2^WIDTH.
REQ-015 The block SHALL drive o_c with the carry out of bit WIDTH-1; for SUB/SUBB, o_c=1 means no borrow (A>=B unsigned).
REQ-016 The block SHALL drive o_v as (A[msb]==B_eff[msb]) && (R[msb]!=A[msb]), where B_eff is the inverted B for SUB/SUBB.
REQ-017 The block SHALL drive o_z=1 exactly when o_result==0, and o_n=o_result[WIDTH-1].
REQ-018 The block SHALL split the datapath into STAGES slices of WIDTH/STAGES bits: stage k adds slice k using the registered carry from stage k-1, and unprocessed operand slices are carried forward in pipeline registers.
REQ-019 The block SHALL have a latency of exactly STAGES cycles: a set accepted at edge t presents o_valid=1 with its result after edge t+STAGES, provided no stall occurs.
REQ-020 The block SHALL sustain a throughput of one operation per cycle while i_ready=1.
REQ-021 The block SHALL use a global advance signal adv = !o_valid || i_ready, with o_ready = adv; the block SHALL NOT use combinational paths from i_valid to o_ready.
REQ-022 When adv=1, all stage registers and stage valid bits SHALL shift by one; when adv=0, all stage registers and valid bits SHALL hold.
REQ-023 Transfers SHALL occur on i_valid&&o_ready (input) and o_valid&&i_ready (output); an accepted set with i_valid=0 SHALL become a bubble (valid bit 0) that propagates without producing output.
REQ-024 While o_valid=1 and i_ready=0, o_result and all flags SHALL stay stable until the transfer.
REQ-025 Results SHALL leave in acceptance order, with none lost or duplicated under any i_ready pattern.
REQ-026 The block SHALL have no internal state beyond the STAGES pipeline registers; it is not a FIFO.

Reset
REQ-027 When i_reset=1 at a rising edge, all stage valid bits SHALL clear, leaving o_valid=0.
REQ-028 Under reset, o_result and the o_c, o_v, o_z, o_n flags SHALL be driven 0.
REQ-029 i_reset SHALL take priority over adv.
REQ-030 Operations in flight at reset SHALL be discarded.
REQ-031 o_ready SHALL be 1 on the first cycle after reset.

Structure
REQ-032 The op encoding (enum add_sub_op_e) SHALL be defined in shared package alu_pkg.
REQ-033 The block SHALL instantiate a combinational sub-module add_sub_slice, parametrised by slice width, with inputs a, b_eff, cin and outputs sum, cout, once per stage via generate.
REQ-034 With STAGES=1 the block SHALL reduce to one registered full-width add_sub.

Verification
REQ-035 With WIDTH=32 and STAGES=4, ADD 0xFFFFFFFF+0x00000001 SHALL give o_result 0x00000000 with C=1 Z=1 V=0 N=0, exactly 4 cycles after acceptance.
REQ-036 SUB 5-7 SHALL give 0xFFFFFFFE with C=0 N=1 V=0 Z=0; SUB 7-5 SHALL give 0x00000002 with C=1.
REQ-037 ADD 0x7FFFFFFF+1 SHALL give 0x80000000 with V=1 N=1 C=0, and ADDC 0x000000FF+0x00000000 with cin=1 SHALL give 0x00000100, with the carry crossing a slice boundary.
REQ-038 Feeding 8 back-to-back ops with i_ready held low for cycles 5-7 SHALL give o_ready=0 during the stall, a held output, all 8 results in order and no loss.
REQ-039 Asserting i_reset for one cycle with 3 ops in flight SHALL give o_valid=0 on the next cycle, no stale result ever emitted, and correct results for new ops after reset.
REQ-040 SUBB 0x00000000-0x00000000 with cin=1 SHALL give 0xFFFFFFFF with C=0 N=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub operation encoding and small decode helpers.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ADDC = 2'b10,
        OP_SUBB = 2'b11
    } add_sub_op_e;

    // Subtracting ops add the inverted B operand.
    function automatic logic op_is_sub(input add_sub_op_e op);
        return (op == OP_SUB) || (op == OP_SUBB);
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// Combinational ripple slice: sum/carry of one WIDTH-bit chunk of the datapath.
module add_sub_slice #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b_eff,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/pipelined_add_sub.sv
// Carry-pipelined adder/subtractor: each stage adds one WIDTH/STAGES slice, with
// a single global advance so the whole pipe shifts or holds together.
module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_c,
    output logic             o_v,
    output logic             o_z,
    output logic             o_n
);

    localparam int SW  = WIDTH / STAGES;
    localparam int FWD = (STAGES > 1) ? STAGES - 1 : 1;

    add_sub_op_e      op;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    logic             adv;

    logic [STAGES-1:0] vld_q;

    // Intermediate stage registers (stage k feeds stage k+1).
    logic [WIDTH-1:0] a_q [FWD];
    logic [WIDTH-1:0] b_q [FWD];
    logic [WIDTH-1:0] r_q [FWD];
    logic             c_q [FWD];

    // Per-stage inputs: ports for stage 0, previous registers otherwise.
    logic [WIDTH-1:0] a_src [STAGES];
    logic [WIDTH-1:0] b_src [STAGES];
    logic [WIDTH-1:0] r_src [STAGES];
    logic             c_src [STAGES];

    logic [WIDTH-1:0] res_q;
    logic             c_out_q, v_q, z_q, n_q;

    assign op      = add_sub_op_e'(i_op);
    assign o_valid = vld_q[STAGES-1];
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    assign o_result = res_q;
    assign o_c      = c_out_q;
    assign o_v      = v_q;
    assign o_z      = z_q;
    assign o_n      = n_q;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        b_eff = op_is_sub(op) ? ~i_b : i_b;
        cin0  = 1'b0;
        case (op)
            OP_SUB:  cin0 = 1'b1;
            OP_ADDC: cin0 = i_cin;
            OP_SUBB: cin0 = ~i_cin;
            default: cin0 = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all stages shift in lockstep.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_q <= '0;
        end else if (adv) begin
            for (int k = STAGES - 1; k > 0; k--) begin
                vld_q[k] <= vld_q[k-1];
            end
            vld_q[0] <= i_valid;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]    sum;
        logic             cout;
        logic [WIDTH-1:0] r_next;

        if (k == 0) begin : g_src_in
            assign a_src[k] = i_a;
            assign b_src[k] = b_eff;
            assign r_src[k] = '0;
            assign c_src[k] = cin0;
        end else begin : g_src_reg
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign r_src[k] = r_q[k-1];
            assign c_src[k] = c_q[k-1];
        end

        add_sub_slice #(.WIDTH(SW)) u_slice (
            .a     (a_src[k][k*SW +: SW]),
            .b_eff (b_src[k][k*SW +: SW]),
            .cin   (c_src[k]),
            .sum   (sum),
            .cout  (cout)
        );

        always_comb begin
            r_next             = r_src[k];
            r_next[k*SW +: SW] = sum;
        end

        if (k < STAGES - 1) begin : g_fwd
            // NOTE: datapath registers are not reset; the cleared valid bits make their contents don't-care.
            always_ff @(posedge i_clk) begin
                if (adv) begin
                    a_q[k] <= a_src[k];
                    b_q[k] <= b_src[k];
                    r_q[k] <= r_next;
                    c_q[k] <= cout;
                end
            end
        end else begin : g_out
            // Flags are registered so they read 0 under reset rather than decoding a zero result.
            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    res_q   <= '0;
                    c_out_q <= 1'b0;
                    v_q     <= 1'b0;
                    z_q     <= 1'b0;
                    n_q     <= 1'b0;
                end else if (adv) begin
                    res_q   <= r_next;
                    c_out_q <= cout;
                    v_q     <= (a_src[k][WIDTH-1] == b_src[k][WIDTH-1]) &&
                               (r_next[WIDTH-1] != a_src[k][WIDTH-1]);
                    z_q     <= (r_next == '0);
                    n_q     <= r_next[WIDTH-1];
                end
            end
        end
    end

endmodule
